// File: rtl/affine_sequencer.sv
// Affine-transform coprocessor: sequences the shared picoMIPS ALU through
// x' = m11*x + m12*y + e and y' = m21*x + m22*y + f, one ALU op per cycle.

`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif
`ifndef ALU_CODE_SIZE
`define ALU_CODE_SIZE 3
`endif
`ifndef RA
`define RA    3'b000
`endif
`ifndef RB
`define RB    3'b001
`endif
`ifndef RADD
`define RADD  3'b010
`endif
`ifndef RMULT
`define RMULT 3'b110
`endif

module affine_sequencer #(
   parameter int n             = `DATA_BUS_SIZE,
   parameter int alu_code_size = `ALU_CODE_SIZE
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [n-1:0]             x_in,
   input  logic [n-1:0]             y_in,
   input  logic [n-1:0]             m11,
   input  logic [n-1:0]             m12,
   input  logic [n-1:0]             m21,
   input  logic [n-1:0]             m22,
   input  logic [n-1:0]             e,
   input  logic [n-1:0]             f,
   output logic [n-1:0]             alu_a,
   output logic [n-1:0]             alu_b,
   output logic [alu_code_size-1:0] alu_func,
   input  logic [n-1:0]             alu_result,
   output logic [n-1:0]             x_out,
   output logic [n-1:0]             y_out,
   output logic                     busy,
   output logic                     done
);

   // state | meaning
   // IDLE  | waiting for start; latches operands on acceptance
   // C1    | acc  <= m11*x
   // C2    | prod <= m12*y
   // C3    | acc  <= acc + prod
   // C4    | xr   <= acc + e
   // C5    | acc  <= m21*x
   // C6    | prod <= m22*y
   // C7    | acc  <= acc + prod
   // C8    | y_out <= acc + f, x_out <= xr
   // DONE  | done pulse, back to IDLE

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      C1   = 4'd1,
      C2   = 4'd2,
      C3   = 4'd3,
      C4   = 4'd4,
      C5   = 4'd5,
      C6   = 4'd6,
      C7   = 4'd7,
      C8   = 4'd8,
      DONE = 4'd9
   } state_t;

   localparam logic [alu_code_size-1:0] FUNC_RB    = alu_code_size'(`RB);
   localparam logic [alu_code_size-1:0] FUNC_RADD  = alu_code_size'(`RADD);
   localparam logic [alu_code_size-1:0] FUNC_RMULT = alu_code_size'(`RMULT);

   state_t state, state_nxt;

   logic [n-1:0] x_r, y_r, m11_r, m12_r, m21_r, m22_r, e_r, f_r;
   logic [n-1:0] acc, prod, xr;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      alu_a     = '0;
      alu_b     = '0;
      alu_func  = FUNC_RB;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = C1;
         end
         C1: begin
            alu_a = m11_r; alu_b = x_r; alu_func = FUNC_RMULT;
            state_nxt = C2;
         end
         C2: begin
            alu_a = m12_r; alu_b = y_r; alu_func = FUNC_RMULT;
            state_nxt = C3;
         end
         C3: begin
            alu_a = acc; alu_b = prod; alu_func = FUNC_RADD;
            state_nxt = C4;
         end
         C4: begin
            alu_a = acc; alu_b = e_r; alu_func = FUNC_RADD;
            state_nxt = C5;
         end
         C5: begin
            alu_a = m21_r; alu_b = x_r; alu_func = FUNC_RMULT;
            state_nxt = C6;
         end
         C6: begin
            alu_a = m22_r; alu_b = y_r; alu_func = FUNC_RMULT;
            state_nxt = C7;
         end
         C7: begin
            alu_a = acc; alu_b = prod; alu_func = FUNC_RADD;
            state_nxt = C8;
         end
         C8: begin
            alu_a = acc; alu_b = f_r; alu_func = FUNC_RADD;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: the ALU result is steered into a destination register by state.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_r   <= '0;
         y_r   <= '0;
         m11_r <= '0;
         m12_r <= '0;
         m21_r <= '0;
         m22_r <= '0;
         e_r   <= '0;
         f_r   <= '0;
         acc   <= '0;
         prod  <= '0;
         xr    <= '0;
         x_out <= '0;
         y_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x_r   <= x_in;
                  y_r   <= y_in;
                  m11_r <= m11;
                  m12_r <= m12;
                  m21_r <= m21;
                  m22_r <= m22;
                  e_r   <= e;
                  f_r   <= f;
               end
            end
            C1, C3, C5, C7: acc  <= alu_result;
            C2, C6:         prod <= alu_result;
            C4:             xr   <= alu_result;
            C8: begin
               y_out <= alu_result;
               x_out <= xr;
            end
            default: ;
         endcase
      end
   end

endmodule
